pong_game_ctrl: RTL

Game-logic core of the pong design. It holds the ball, both paddles, both scores and the game state on a tile grid, and advances them on tick counters. It sits downstream of the four debounced switches and the UART data_valid start pulse. It feeds the pixel renderer, which maps tile coordinates onto the sync_pulse column and row counters. It produces no pixels itself.

---
 rtl/pong_pkg.sv | 14 +
 rtl/pong_paddle_ctrl.sv | 43 ++++
 rtl/pong_game_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and grid defaults for the pong game logic
package pong_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_P1_WON  = 2'd2,
        ST_P2_WON  = 2'd3
    } state_e;
    localparam int DEF_GAME_WIDTH  = 40;
    localparam int DEF_GAME_HEIGHT = 30;
    localparam int TILE_SIZE       = 16;
    localparam int DEF_CW          = $clog2(DEF_GAME_WIDTH);
    localparam int DEF_RW          = $clog2(DEF_GAME_HEIGHT);
endpackage

// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl: one paddle, stepped every PADDLE_SPEED clocks while exactly one switch is held
module pong_paddle_ctrl #(
    parameter int GAME_HEIGHT   = 30,
    parameter int PADDLE_HEIGHT = 6,
    parameter int PADDLE_SPEED  = 1250000,
    localparam int RW           = $clog2(GAME_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_up,
    input  logic          i_dn,
    output logic [RW-1:0] o_y
);
    localparam int SCW = $clog2(PADDLE_SPEED + 1);
    localparam logic [SCW-1:0] S_TC = SCW'(PADDLE_SPEED - 1);
    localparam logic [RW-1:0] Y_MAX = RW'(GAME_HEIGHT - PADDLE_HEIGHT);
    localparam logic [RW-1:0] Y_RST = RW'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);

    logic [SCW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]  y_q, y_d;
    logic           move, tick;

    always_comb begin
        move  = i_up ^ i_dn;
        tick  = move && (cnt_q == S_TC);
        cnt_d = (!move || tick) ? '0 : cnt_q + SCW'(1);
        y_d   = !tick ? y_q :
                i_up  ? ((y_q == '0)    ? y_q : y_q - RW'(1)) :
                        ((y_q == Y_MAX) ? y_q : y_q + RW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            y_q   <= Y_RST;
        end else begin
            cnt_q <= cnt_d;
            y_q   <= y_d;
        end
    end

    assign o_y = y_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game state, ball motion, paddle hits and scoring on a tile grid
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int GAME_WIDTH    = DEF_GAME_WIDTH,
    parameter int GAME_HEIGHT   = DEF_GAME_HEIGHT,
    parameter int PADDLE_HEIGHT = 6,
    parameter int BALL_SPEED    = 1250000,
    parameter int PADDLE_SPEED  = 1250000,
    parameter int SCORE_LIMIT   = 9,
    localparam int CW           = $clog2(GAME_WIDTH),
    localparam int RW           = $clog2(GAME_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_p1_up,
    input  logic          i_p1_dn,
    input  logic          i_p2_up,
    input  logic          i_p2_dn,
    output logic [CW-1:0] o_ball_x,
    output logic [RW-1:0] o_ball_y,
    output logic [RW-1:0] o_p1_y,
    output logic [RW-1:0] o_p2_y,
    output logic [3:0]    o_p1_score,
    output logic [3:0]    o_p2_score,
    output logic [1:0]    o_state
);
    localparam int BCW = $clog2(BALL_SPEED + 1);
    localparam logic [BCW-1:0] B_TC   = BCW'(BALL_SPEED - 1);
    localparam logic [CW-1:0]  X_CTR  = CW'(GAME_WIDTH / 2);
    localparam logic [CW-1:0]  X_NEAR = CW'(GAME_WIDTH - 2);
    localparam logic [CW-1:0]  X_MAX  = CW'(GAME_WIDTH - 1);
    localparam logic [RW-1:0]  Y_CTR  = RW'(GAME_HEIGHT / 2);
    localparam logic [RW-1:0]  Y_MAX  = RW'(GAME_HEIGHT - 1);
    localparam logic [RW:0]    PH     = (RW + 1)'(PADDLE_HEIGHT);
    localparam logic [3:0]     LIMIT  = 4'(SCORE_LIMIT);

    state_e         state_q, state_d;
    logic [CW-1:0]  ball_x_q, ball_x_d;
    logic [RW-1:0]  ball_y_q, ball_y_d;
    logic           dx_q, dx_d, dy_q, dy_d;
    logic [BCW-1:0] cnt_q, cnt_d;
    logic [3:0]     p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [RW-1:0]  p1_y, p2_y;
    logic           tick, hit1, hit2, miss_l, miss_r;

    pong_paddle_ctrl #(
        .GAME_HEIGHT(GAME_HEIGHT), .PADDLE_HEIGHT(PADDLE_HEIGHT), .PADDLE_SPEED(PADDLE_SPEED)
    ) u_p1 (.clk(clk), .rst(rst), .i_up(i_p1_up), .i_dn(i_p1_dn), .o_y(p1_y));

    pong_paddle_ctrl #(
        .GAME_HEIGHT(GAME_HEIGHT), .PADDLE_HEIGHT(PADDLE_HEIGHT), .PADDLE_SPEED(PADDLE_SPEED)
    ) u_p2 (.clk(clk), .rst(rst), .i_up(i_p2_up), .i_dn(i_p2_dn), .o_y(p2_y));

    // one extra bit so paddle bottom row arithmetic cannot wrap
    assign hit1   = ({1'b0, ball_y_q} >= {1'b0, p1_y}) && ({1'b0, ball_y_q} < {1'b0, p1_y} + PH);
    assign hit2   = ({1'b0, ball_y_q} >= {1'b0, p2_y}) && ({1'b0, ball_y_q} < {1'b0, p2_y} + PH);
    assign tick   = (state_q == ST_RUNNING) && (cnt_q == B_TC);
    assign miss_l = tick && !dx_q && (ball_x_q == '0);
    assign miss_r = tick && dx_q && (ball_x_q == X_MAX);

    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        cnt_d      = '0;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        if (state_q == ST_IDLE) begin
            ball_x_d = X_CTR;
            ball_y_d = Y_CTR;
            state_d  = i_start ? ST_RUNNING : ST_IDLE;
        end else if (state_q == ST_RUNNING) begin
            cnt_d = tick ? '0 : cnt_q + BCW'(1);
            if (tick) begin
                if ((ball_y_q == '0 && !dy_q) || (ball_y_q == Y_MAX && dy_q))
                    dy_d = !dy_q;
                else
                    ball_y_d = dy_q ? ball_y_q + RW'(1) : ball_y_q - RW'(1);
                if (!dx_q) begin
                    if (ball_x_q == CW'(1)) begin
                        if (hit1) dx_d = 1'b1;
                        else ball_x_d = '0;
                    end else if (ball_x_q != '0) begin
                        ball_x_d = ball_x_q - CW'(1);
                    end
                end else begin
                    if (ball_x_q == X_NEAR) begin
                        if (hit2) dx_d = 1'b0;
                        else ball_x_d = X_MAX;
                    end else if (ball_x_q != X_MAX) begin
                        ball_x_d = ball_x_q + CW'(1);
                    end
                end
                // serve goes toward whoever conceded
                if (miss_l || miss_r) begin
                    ball_x_d   = X_CTR;
                    ball_y_d   = Y_CTR;
                    dx_d       = miss_r;
                    p1_score_d = p1_score_q + 4'(miss_r);
                    p2_score_d = p2_score_q + 4'(miss_l);
                    state_d    = (p1_score_d == LIMIT) ? ST_P1_WON :
                                 (p2_score_d == LIMIT) ? ST_P2_WON : ST_IDLE;
                end
            end
        end else if (i_start) begin
            p1_score_d = '0;
            p2_score_d = '0;
            ball_x_d   = X_CTR;
            ball_y_d   = Y_CTR;
            state_d    = ST_RUNNING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ball_x_q   <= X_CTR;
            ball_y_q   <= Y_CTR;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            cnt_q      <= '0;
            p1_score_q <= '0;
            p2_score_q <= '0;
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            cnt_q      <= cnt_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
        end
    end

    assign o_ball_x   = ball_x_q;
    assign o_ball_y   = ball_y_q;
    assign o_p1_y     = p1_y;
    assign o_p2_y     = p2_y;
    assign o_p1_score = p1_score_q;
    assign o_p2_score = p2_score_q;
    assign o_state    = state_q;
endmodule
